// File: rtl/prng_pkg.sv
// Shared constants, FSM state type and LCG step function for the PRNG arbiter.
package prng_pkg;

   localparam logic [31:0] LCG_MULTIPLIER = 32'h6B9F42D3;
   localparam logic [31:0] LCG_INCREMENT  = 32'h1C37FA88;

   typedef enum logic [0:0] {
      WARMUP = 1'b0,
      SERVE  = 1'b1
   } prng_state_e;

   // One LCG advance; the product is truncated to 32 bits before the add.
   function automatic logic [31:0] lcg_next(input logic [31:0] cur);
      return (cur * LCG_MULTIPLIER) + LCG_INCREMENT;
   endfunction

endpackage

// File: rtl/prng_lcg_core.sv
// 32-bit LCG state register. A load has priority over a step.
module prng_lcg_core
   import prng_pkg::*;
#(
   parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        step,
   output logic [31:0] state
);

   logic [31:0] state_reg;

   // Load a new seed, or advance once when asked; otherwise hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= SEED_DEFAULT;
      end else if (load) begin
         state_reg <= load_val;
      end else if (step) begin
         state_reg <= lcg_next(state_reg);
      end
   end

   assign state = state_reg;

endmodule

// File: rtl/prng_req_arbiter.sv
// Round-robin arbiter handing out distinct LCG words to NUM_REQ requesters.
// A warm-up phase after reset or seed load hides the raw seed from consumers.
module prng_req_arbiter
   import prng_pkg::*;
#(
   parameter int          NUM_REQ      = 4,
   parameter int          WARMUP_STEPS = 8,
   parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               seed_load,
   input  logic [31:0]        seed_in,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [31:0]        rand_out,
   output logic               rand_valid,
   output logic               ready
);

   localparam int               IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam prng_state_e      START_STATE = (WARMUP_STEPS == 0) ? SERVE : WARMUP;
   localparam logic [7:0]       WCNT_LAST   = (WARMUP_STEPS == 0) ? 8'd0 : 8'(WARMUP_STEPS - 1);
   localparam logic [IDX_W-1:0] LAST_RESET  = IDX_W'(NUM_REQ - 1);

   prng_state_e        state_reg, state_next;
   logic [7:0]         wcnt_reg, wcnt_next;
   logic [IDX_W-1:0]   last_reg;
   logic [NUM_REQ-1:0] gnt_reg;
   logic [31:0]        rand_out_reg;
   logic               rand_valid_reg;

   logic [31:0]        lcg_state;
   logic               lcg_step;
   logic               grant_fire;
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [NUM_REQ-1:0] win_onehot;

   prng_lcg_core #(
      .SEED_DEFAULT(SEED_DEFAULT)
   ) u_lcg (
      .clk      (clk),
      .rst      (rst),
      .load     (seed_load),
      .load_val (seed_in),
      .step     (lcg_step),
      .state    (lcg_state)
   );

   // Round-robin search: first set request starting just after the last winner.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      cand      = 0;
      cand_idx  = '0;
      win_found = 1'b0;
      win_idx   = last_reg;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand     = (int'(last_reg) + i) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!win_found && req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
         assign win_onehot[gi] = win_found && (win_idx == IDX_W'(gi));
      end
   endgenerate

   // Next-state logic: seed load overrides everything and suppresses grants.
   always_comb begin
      state_next = state_reg;
      wcnt_next  = wcnt_reg;
      lcg_step   = 1'b0;
      grant_fire = 1'b0;
      if (seed_load) begin
         state_next = START_STATE;
         wcnt_next  = 8'd0;
      end else begin
         case (state_reg)
            WARMUP: begin
               lcg_step = 1'b1;
               if (wcnt_reg == WCNT_LAST) begin
                  state_next = SERVE;
                  wcnt_next  = 8'd0;
               end else begin
                  wcnt_next = wcnt_reg + 8'd1;
               end
            end
            SERVE: begin
               grant_fire = win_found;
               lcg_step   = win_found;
            end
            default: state_next = START_STATE;
         endcase
      end
   end

   // FSM state and warm-up counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= START_STATE;
         wcnt_reg  <= 8'd0;
      end else begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
      end
   end

   // Remember the winner; a seed load leaves the pointer untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_reg <= LAST_RESET;
      end else if (grant_fire) begin
         last_reg <= win_idx;
      end
   end

   // Registered one-cycle grant with the pre-advance LCG word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_reg        <= '0;
         rand_out_reg   <= '0;
         rand_valid_reg <= 1'b0;
      end else begin
         gnt_reg        <= grant_fire ? win_onehot : '0;
         rand_out_reg   <= grant_fire ? lcg_state : 32'd0;
         rand_valid_reg <= grant_fire;
      end
   end

   assign gnt        = gnt_reg;
   assign rand_out   = rand_out_reg;
   assign rand_valid = rand_valid_reg;
   assign ready      = (state_reg == SERVE);

endmodule

// File: tb/tb_prng_req_arbiter.sv
// Bench for prng_req_arbiter: vector table, directed corner cases and a
// randomized run against a behavioural model.
module tb_prng_req_arbiter;

   localparam int          N        = 4;
   localparam int          W        = 8;
   localparam logic [31:0] SEED_DEF = 32'h0000_0001;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        seed_load;
   logic [31:0] seed_in;
   logic [3:0]  req;
   logic [3:0]  gnt;
   logic [31:0] rand_out;
   logic        rand_valid;
   logic        ready;

   logic        z_seed_load;
   logic [31:0] z_seed_in;
   logic [3:0]  z_req;
   logic [3:0]  z_gnt;
   logic [31:0] z_rand_out;
   logic        z_rand_valid;
   logic        z_ready;

   int tests = 0;
   int fails = 0;

   prng_req_arbiter #(
      .NUM_REQ      (N),
      .WARMUP_STEPS (W),
      .SEED_DEFAULT (SEED_DEF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .req        (req),
      .gnt        (gnt),
      .rand_out   (rand_out),
      .rand_valid (rand_valid),
      .ready      (ready)
   );

   prng_req_arbiter #(
      .NUM_REQ      (N),
      .WARMUP_STEPS (0),
      .SEED_DEFAULT (SEED_DEF)
   ) dut0 (
      .clk        (clk),
      .rst        (rst),
      .seed_load  (z_seed_load),
      .seed_in    (z_seed_in),
      .req        (z_req),
      .gnt        (z_gnt),
      .rand_out   (z_rand_out),
      .rand_valid (z_rand_valid),
      .ready      (z_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_lcg(input logic [31:0] s);
      return (s * 32'h6B9F42D3) + 32'h1C37FA88;
   endfunction

   function automatic logic [31:0] ref_lcg_n(input logic [31:0] s, input int n);
      logic [31:0] v;
      v = s;
      for (int k = 0; k < n; k++) v = ref_lcg(v);
      return v;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic        sl;
      logic [31:0] sin;
      logic [3:0]  rq;
      logic [3:0]  egnt;
      logic        evalid;
      logic        eready;
      logic [31:0] ebase;
      int          esteps;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic sl, input logic [31:0] sin, input logic [3:0] rq,
                      input logic [3:0] egnt, input logic evalid, input logic eready,
                      input logic [31:0] ebase, input int esteps);
      vec_t v;
      v.sl = sl; v.sin = sin; v.rq = rq; v.egnt = egnt;
      v.evalid = evalid; v.eready = eready; v.ebase = ebase; v.esteps = esteps;
      vecs.push_back(v);
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_lcg;
   int          m_warm;
   int          m_last;
   logic [3:0]  m_gnt;
   logic        m_valid;
   logic [31:0] m_rout;

   task automatic model_reset();
      m_lcg   = SEED_DEF;
      m_warm  = W;
      m_last  = N - 1;
      m_gnt   = '0;
      m_valid = 1'b0;
      m_rout  = '0;
   endtask

   task automatic model_step(input logic sl, input logic [31:0] sin, input logic [3:0] rq);
      int w;
      m_gnt   = '0;
      m_valid = 1'b0;
      m_rout  = '0;
      if (sl) begin
         m_lcg  = sin;
         m_warm = W;
      end else if (m_warm > 0) begin
         m_lcg  = ref_lcg(m_lcg);
         m_warm = m_warm - 1;
      end else begin
         w = -1;
         for (int k = 1; k <= N; k++) begin
            if (w < 0 && rq[(m_last + k) % N]) w = (m_last + k) % N;
         end
         if (w >= 0) begin
            m_gnt    = 4'(1 << w);
            m_valid  = 1'b1;
            m_rout   = m_lcg;
            m_lcg    = ref_lcg(m_lcg);
            m_last   = w;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int cyc;

      rst = 1'b0; seed_load = 1'b0; seed_in = '0; req = '0;
      z_seed_load = 1'b0; z_seed_in = '0; z_req = '0;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_valid", 32'(rand_valid), 32'd0);
      check("rst_rout", rand_out, 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_ready_w0", 32'(z_ready), 32'd1);
      rst = 1'b1;

      // ---- table: warm-up, round robin, 1010 after last=1, seed+req collision ----
      for (int k = 0; k < W - 1; k++) add(1'b0, 32'd0, 4'b1111, 4'b0000, 1'b0, 1'b0, 32'd0, 0);
      add(1'b0, 32'd0, 4'b1111, 4'b0000, 1'b0, 1'b1, 32'd0, 0);
      add(1'b0, 32'd0, 4'b1111, 4'b0001, 1'b1, 1'b1, SEED_DEF, 8);
      add(1'b0, 32'd0, 4'b1111, 4'b0010, 1'b1, 1'b1, SEED_DEF, 9);
      add(1'b0, 32'd0, 4'b1111, 4'b0100, 1'b1, 1'b1, SEED_DEF, 10);
      add(1'b0, 32'd0, 4'b1111, 4'b1000, 1'b1, 1'b1, SEED_DEF, 11);
      add(1'b0, 32'd0, 4'b1111, 4'b0001, 1'b1, 1'b1, SEED_DEF, 12);
      add(1'b0, 32'd0, 4'b1111, 4'b0010, 1'b1, 1'b1, SEED_DEF, 13);
      add(1'b0, 32'd0, 4'b1010, 4'b1000, 1'b1, 1'b1, SEED_DEF, 14);
      add(1'b0, 32'd0, 4'b1010, 4'b0010, 1'b1, 1'b1, SEED_DEF, 15);
      add(1'b1, 32'hDEADBEEF, 4'b0100, 4'b0000, 1'b0, 1'b0, 32'd0, 0);
      for (int k = 0; k < W - 1; k++) add(1'b0, 32'd0, 4'b0100, 4'b0000, 1'b0, 1'b0, 32'd0, 0);
      add(1'b0, 32'd0, 4'b0100, 4'b0000, 1'b0, 1'b1, 32'd0, 0);
      add(1'b0, 32'd0, 4'b0100, 4'b0100, 1'b1, 1'b1, 32'hDEADBEEF, 8);
      add(1'b0, 32'd0, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'd0, 0);

      foreach (vecs[i]) begin
         seed_load = vecs[i].sl;
         seed_in   = vecs[i].sin;
         req       = vecs[i].rq;
         @(posedge clk);
         #1;
         $display("[TB] vec %0d sl=%b req=%b -> gnt=%b valid=%b ready=%b rout=%h",
                  i, vecs[i].sl, vecs[i].rq, gnt, rand_valid, ready, rand_out);
         check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].egnt));
         check($sformatf("vec%0d_valid", i), 32'(rand_valid), 32'(vecs[i].evalid));
         check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].eready));
         if (vecs[i].evalid)
            check($sformatf("vec%0d_rout", i), rand_out, ref_lcg_n(vecs[i].ebase, vecs[i].esteps));
      end
      seed_load = 1'b0; req = '0;

      // ---- WARMUP_STEPS = 0: seed 0, two grants to requester 0 ----
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check("w0_ready_after_rst", 32'(z_ready), 32'd1);
      z_seed_load = 1'b1; z_seed_in = 32'd0; z_req = 4'b0001;
      @(posedge clk);
      #1;
      $display("[TB] w0 seed_load+req -> gnt=%b ready=%b", z_gnt, z_ready);
      check("w0_seed_gnt", 32'(z_gnt), 32'd0);
      check("w0_seed_valid", 32'(z_rand_valid), 32'd0);
      check("w0_seed_ready", 32'(z_ready), 32'd1);
      z_seed_load = 1'b0;
      @(posedge clk);
      #1;
      $display("[TB] w0 grant1 gnt=%b rout=%h", z_gnt, z_rand_out);
      check("w0_g1_gnt", 32'(z_gnt), 32'd1);
      check("w0_g1_valid", 32'(z_rand_valid), 32'd1);
      check("w0_g1_rout", z_rand_out, 32'h00000000);
      @(posedge clk);
      #1;
      $display("[TB] w0 grant2 gnt=%b rout=%h", z_gnt, z_rand_out);
      check("w0_g2_gnt", 32'(z_gnt), 32'd1);
      check("w0_g2_rout", z_rand_out, 32'h1C37FA88);
      z_req = 4'b0000;
      @(posedge clk);
      #1;
      check("w0_idle_gnt", 32'(z_gnt), 32'd0);

      // ---- asynchronous reset while a grant is visible ----
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      req = 4'b1111;
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(posedge clk);
         #1;
         if (gnt != 4'b0000) found = 1'b1;
      end
      check("arst_saw_gnt", 32'(found), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      $display("[TB] async reset mid-grant -> gnt=%b valid=%b rout=%h", gnt, rand_valid, rand_out);
      check("arst_gnt", 32'(gnt), 32'd0);
      check("arst_valid", 32'(rand_valid), 32'd0);
      check("arst_rout", rand_out, 32'd0);
      check("arst_ready", 32'(ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      cyc = 0;
      found = 1'b0;
      for (int c = 1; c <= 20 && !found; c++) begin
         @(posedge clk);
         #1;
         if (gnt != 4'b0000) begin
            found = 1'b1;
            cyc = c;
         end
      end
      $display("[TB] restart first grant cycle=%0d gnt=%b rout=%h", cyc, gnt, rand_out);
      check("restart_cycle", 32'(cyc), 32'(W + 1));
      check("restart_gnt", 32'(gnt), 32'd1);
      check("restart_rout", rand_out, ref_lcg_n(SEED_DEF, W));
      req = '0;

      // ---- randomized run against the model ----
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b1;
      for (int t = 0; t < 400; t++) begin
         seed_load = ($urandom_range(0, 39) == 0);
         seed_in   = $urandom;
         req       = 4'($urandom_range(0, 15));
         @(posedge clk);
         model_step(seed_load, seed_in, req);
         #1;
         if (m_valid)
            $display("[TB] rnd %0d req=%b gnt=%b rout=%h", t, req, gnt, rand_out);
         check($sformatf("rnd%0d_gnt", t), 32'(gnt), 32'(m_gnt));
         check($sformatf("rnd%0d_valid", t), 32'(rand_valid), 32'(m_valid));
         check($sformatf("rnd%0d_ready", t), 32'(ready), 32'(m_warm == 0));
         if (m_valid)
            check($sformatf("rnd%0d_rout", t), rand_out, m_rout);
      end
      seed_load = 1'b0; req = '0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
